// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its load FIFO.
// Optional load extension is enabled by defining WB_LOAD_EXT_EN.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
        logic [2:0]            funct3;
        logic [1:0]            byteOff;
    } ld_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Circular buffer holding pending load results; head is read combinationally
// so a pop can register the result in the same cycle.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  ld_entry_t wr_entry,
    output ld_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    ld_entry_t          mem [DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [AW:0]        count_reg;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    // Storage carries no reset: stale entries are never visible past the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and buffered load results onto the register file write port.
// Define WB_LOAD_EXT_EN to extract/extend sub-word loads at pop time.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  aluValid,
    output logic                  aluReady,
    input  logic [REG_ADDR_W-1:0] aluRd,
    input  logic [XLEN-1:0]       aluData,
    input  logic                  ldValid,
    output logic                  ldReady,
    input  logic [REG_ADDR_W-1:0] ldRd,
    input  logic [XLEN-1:0]       ldData,
    input  logic [2:0]            ldFunct3,
    input  logic [1:0]            ldByteOff,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] wrAddr,
    output logic [XLEN-1:0]       wrData,
    output logic                  ldPending
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    ld_entry_t         push_entry;
    ld_entry_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              alu_write;
    logic              force_pop;
    logic [CW-1:0]     starve_reg;
    logic [CW-1:0]     starve_next;
    logic [XLEN-1:0]   load_result;

    wb_load_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .wr_entry (push_entry),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Readies come only from registered state so upstream sees no comb loop.
    assign force_pop = !fifo_empty && (starve_reg == CW'(STARVE_LIMIT));
    assign aluReady  = !force_pop;
    assign ldReady   = !rst && !fifo_full;
    assign ldPending = !fifo_empty;

    assign alu_write = aluValid && aluReady && (aluRd != '0);
    assign pop       = !fifo_empty && !alu_write;
    assign push      = ldValid && ldReady && (ldRd != '0);

    always_comb begin
        starve_next = starve_reg;
        if (fifo_empty || pop) begin
            starve_next = '0;
        end else if (alu_write) begin
            starve_next = starve_reg + CW'(1);
        end
    end

`ifdef WB_LOAD_EXT_EN
    function automatic logic [XLEN-1:0] extend_load(input ld_entry_t e);
        logic [7:0]  b;
        logic [15:0] h;
        b = e.data[{e.byteOff, 3'b000} +: 8];
        h = e.byteOff[1] ? e.data[31:16] : e.data[15:0];
        case (e.funct3)
            F3_LB:   extend_load = {{24{b[7]}}, b};
            F3_LBU:  extend_load = {24'h0, b};
            F3_LH:   extend_load = {{16{h[15]}}, h};
            F3_LHU:  extend_load = {16'h0, h};
            default: extend_load = e.data;
        endcase
    endfunction

    assign push_entry  = '{rd: ldRd, data: ldData, funct3: ldFunct3, byteOff: ldByteOff};
    assign load_result = extend_load(head);
`else
    logic unused_ld_meta;

    assign push_entry     = '{rd: ldRd, data: ldData, funct3: 3'b000, byteOff: 2'b00};
    assign load_result    = head.data;
    assign unused_ld_meta = ^{ldFunct3, ldByteOff, head.funct3, head.byteOff};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we         <= 1'b0;
            wrAddr     <= '0;
            wrData     <= '0;
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
            if (alu_write) begin
                we     <= 1'b1;
                wrAddr <= aluRd;
                wrData <= aluData;
            end else if (pop) begin
                we     <= 1'b1;
                wrAddr <= head.rd;
                wrData <= load_result;
            end else begin
                we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with per-source scoreboards.
module tb_writeback_arbiter;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        aluValid, aluReady;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        ldValid, ldReady;
    logic [4:0]  ldRd;
    logic [31:0] ldData;
    logic [2:0]  ldFunct3;
    logic [1:0]  ldByteOff;
    logic        we;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic        ldPending;

    int checks = 0;
    int errors = 0;
    wr_t alu_q[$];
    wr_t ld_q[$];

    writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .aluValid(aluValid), .aluReady(aluReady), .aluRd(aluRd), .aluData(aluData),
        .ldValid(ldValid), .ldReady(ldReady), .ldRd(ldRd), .ldData(ldData),
        .ldFunct3(ldFunct3), .ldByteOff(ldByteOff),
        .we(we), .wrAddr(wrAddr), .wrData(wrData), .ldPending(ldPending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((alu_q.size() + ld_q.size()) != 0 && n < 60) begin
            step();
            n++;
        end
        check(tag, alu_q.size() + ld_q.size(), 0);
    endtask

    // Every write seen on the port must match the head of its source's queue.
    always @(negedge clk) begin
        wr_t e;
        if (!rst && we) begin
            checks++;
            if (wrAddr <= 5'd2) begin
                assert (alu_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_alu_write: observed x%0d=%h expected no write", wrAddr, wrData);
                end
                if (alu_q.size() != 0) begin
                    e = alu_q.pop_front();
                    check("alu_wr_addr", wrAddr, e.rd);
                    check("alu_wr_data", wrData, e.data);
                end
            end else begin
                assert (ld_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_ld_write: observed x%0d=%h expected no write", wrAddr, wrData);
                end
                if (ld_q.size() != 0) begin
                    e = ld_q.pop_front();
                    check("ld_wr_addr", wrAddr, e.rd);
                    check("ld_wr_data", wrData, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ld_n;
        int n;
        bit chk4;
        bit alu_acc, ld_acc;

        // Reset with traffic applied
        rst = 1'b1;
        aluValid = 1'b1; aluRd = 5'd5; aluData = 32'h1111_1111;
        ldValid = 1'b1; ldRd = 5'd6; ldData = 32'h2222_2222; ldFunct3 = 3'b010; ldByteOff = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", we, 1'b0);
        check("rst_wrAddr", wrAddr, 5'd0);
        check("rst_wrData", wrData, 32'h0);
        check("rst_ldPending", ldPending, 1'b0);
        check("rst_ldReady", ldReady, 1'b0);
        check("rst_aluReady", aluReady, 1'b1);
        rst = 1'b0; aluValid = 1'b0; ldValid = 1'b0;
        #1;
        check("ldReady_after_rst", ldReady, 1'b1);
        step();

        // Single ALU write
        aluValid = 1'b1; aluRd = 5'd1; aluData = 32'hDEADBEEF;
        alu_q.push_back('{5'd1, 32'hDEADBEEF});
        step();
        aluValid = 1'b0;
        check("alu_we", we, 1'b1);
        check("alu_addr", wrAddr, 5'd1);
        check("alu_data", wrData, 32'hDEADBEEF);
        step();

        // Starvation: ALU hammers x2 while one LW to x3 waits
        aluValid = 1'b1; aluRd = 5'd2;
        for (int k = 0; k < 5; k++) begin
            aluData = 32'hA000_0000 + k;
            alu_q.push_back('{5'd2, 32'hA000_0000 + k});
            if (k == 0) begin
                ldValid = 1'b1; ldRd = 5'd3; ldData = 32'h12345678; ldFunct3 = 3'b010; ldByteOff = 2'd0;
            end
            check("starve_aluReady_high", aluReady, 1'b1);
            step();
            ldValid = 1'b0;
        end
        check("starve_aluReady_low", aluReady, 1'b0);
        ld_q.push_back('{5'd3, 32'h12345678});
        aluData = 32'hA000_0005;
        alu_q.push_back('{5'd2, 32'hA000_0005});
        step();
        check("starve_force_addr", wrAddr, 5'd3);
        check("starve_force_data", wrData, 32'h12345678);
        check("starve_aluReady_back", aluReady, 1'b1);
        step();
        aluValid = 1'b0;
        drain("starve_drain");

        // FIFO full: five loads x4..x8 against continuous ALU traffic
        aluValid = 1'b1; aluRd = 5'd2; aluData = 32'hB000_0000;
        ldValid = 1'b1; ldRd = 5'd4; ldData = 32'hC000_0000; ldFunct3 = 3'b010; ldByteOff = 2'd0;
        ld_n = 0; n = 0; chk4 = 1'b0;
        while (ld_n < 5 && n < 100) begin
            if (ld_n == 4 && !chk4) begin
                check("full_ldReady_low", ldReady, 1'b0);
                check("full_ldPending", ldPending, 1'b1);
                chk4 = 1'b1;
            end
            alu_acc = aluValid && aluReady;
            ld_acc  = ldValid && ldReady;
            if (alu_acc) alu_q.push_back('{5'd2, aluData});
            if (ld_acc)  ld_q.push_back('{ldRd, ldData});
            step();
            n++;
            if (alu_acc) aluData = aluData + 32'd1;
            if (ld_acc) begin
                ld_n++;
                if (ld_n == 5) begin
                    ldValid = 1'b0;
                end else begin
                    ldRd = 5'd4 + 5'(ld_n);
                    ldData = 32'hC000_0000 + ld_n;
                end
            end
        end
        aluValid = 1'b0; ldValid = 1'b0;
        check("full_fifth_accepted", ld_n, 5);
        drain("full_drain");

        // x0 suppression on both paths
        aluValid = 1'b1; aluRd = 5'd0; aluData = 32'hFFFF_FFFF;
        ldValid = 1'b1; ldRd = 5'd0; ldData = 32'hEEEE_EEEE;
        for (int k = 0; k < 4; k++) begin
            step();
            check("x0_we", we, 1'b0);
            check("x0_ldPending", ldPending, 1'b0);
        end
        aluValid = 1'b0; ldValid = 1'b0;
        step();

        // A consumed x0 ALU result leaves the slot for a waiting load
        aluValid = 1'b1; aluRd = 5'd2; aluData = 32'h0000_0A11;
        alu_q.push_back('{5'd2, 32'h0000_0A11});
        ldValid = 1'b1; ldRd = 5'd9; ldData = 32'h0000_0999;
        ld_q.push_back('{5'd9, 32'h0000_0999});
        step();
        ldValid = 1'b0; aluRd = 5'd0;
        step();
        aluValid = 1'b0;
        check("x0_slot_we", we, 1'b1);
        check("x0_slot_addr", wrAddr, 5'd9);
        drain("x0_drain");

        // Sub-word extraction on ldData = 0x80FF7F01
        ldData = 32'h80FF7F01; ldValid = 1'b1;
        ldRd = 5'd10; ldFunct3 = 3'b000; ldByteOff = 2'd3;
`ifdef WB_LOAD_EXT_EN
        ld_q.push_back('{5'd10, 32'hFFFFFF80});
`else
        ld_q.push_back('{5'd10, 32'h80FF7F01});
`endif
        step();
        ldRd = 5'd11; ldFunct3 = 3'b100; ldByteOff = 2'd1;
`ifdef WB_LOAD_EXT_EN
        ld_q.push_back('{5'd11, 32'h0000007F});
`else
        ld_q.push_back('{5'd11, 32'h80FF7F01});
`endif
        step();
        check("ld_latency_we", we, 1'b1);
        check("ld_latency_addr", wrAddr, 5'd10);
        ldRd = 5'd12; ldFunct3 = 3'b001; ldByteOff = 2'd2;
`ifdef WB_LOAD_EXT_EN
        ld_q.push_back('{5'd12, 32'hFFFF80FF});
`else
        ld_q.push_back('{5'd12, 32'h80FF7F01});
`endif
        step();
        ldRd = 5'd13; ldFunct3 = 3'b101; ldByteOff = 2'd0;
`ifdef WB_LOAD_EXT_EN
        ld_q.push_back('{5'd13, 32'h00007F01});
`else
        ld_q.push_back('{5'd13, 32'h80FF7F01});
`endif
        step();
        ldValid = 1'b0;
        drain("ext_drain");

        // Reset mid-operation drops the queued load and the write strobe
        aluValid = 1'b1; aluRd = 5'd2; aluData = 32'hD000_0000;
        alu_q.push_back('{5'd2, 32'hD000_0000});
        ldValid = 1'b1; ldRd = 5'd5; ldData = 32'h5555_5555; ldFunct3 = 3'b010;
        step();
        ldValid = 1'b0; aluData = 32'hD000_0001;
        alu_q.push_back('{5'd2, 32'hD000_0001});
        check("midrst_ldPending_before", ldPending, 1'b1);
        step();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_we", we, 1'b0);
        check("midrst_ldPending", ldPending, 1'b0);
        aluValid = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        check("midrst_no_write", we, 1'b0);
        check("midrst_queues", alu_q.size() + ld_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
